// File: rtl/alu_sequencer_project_id.sv
// ----------------------------------------------------------------------------
// alu_sequencer_project_id
//
// Purpose: instruction sequencer for a 4-bit accumulator machine. An
// eight-phase bus cycle (A1-A3, M1, M2, X1-X3) fetches an opcode nibble (OPR)
// in M1 and an operand nibble (OPA) in M2. The latched OPR:OPA pair is decoded
// into ALU operand/operation selects for an external ALU. The accumulator,
// carry flag and register-file write strobe are committed from the ALU
// result on the edge that ends X1.
//
// Ports:
//   clock       - sole clock, rising edge
//   reset       - synchronous, active-high
//   data_in     - instruction bus nibble
//   result      - ALU result {carry_out, sum}
//   alu_op      - ALU operation (ADD=0, ROL=1, ROR=2, PASS=3)
//   alu_in0_sel - operand 0 (ACC, ACC_INV, REG, REG_INV, DATA, DATA_INV)
//   alu_in1_sel - operand 1 (ACC, REG, ONE, ONE_INV)
//   alu_cin_sel - carry in (ZERO, ONE, CARRY, CARRY_INV)
//   alu_data    - latched OPA, ALU data operand
//   acc         - accumulator
//   carry       - carry flag
//   reg_idx     - register-file index (latched OPA)
//   reg_we      - register-file write strobe (X1 of INC only)
//   reg_wdata   - register-file write data (result sum)
//   phase       - current bus phase 0..7
//   sync        - high during X3
// ----------------------------------------------------------------------------
module alu_sequencer_project_id #(
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W:0]   result,
  output logic [2:0]        alu_op,
  output logic [2:0]        alu_in0_sel,
  output logic [1:0]        alu_in1_sel,
  output logic [1:0]        alu_cin_sel,
  output logic [DATA_W-1:0] alu_data,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic [DATA_W-1:0] reg_idx,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [2:0]        phase,
  output logic              sync
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_ROL = 3'd1, ALU_ROR = 3'd2, ALU_PASS = 3'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    IN0_ACC = 3'd0, IN0_ACC_INV = 3'd1, IN0_REG = 3'd2,
    IN0_REG_INV = 3'd3, IN0_DATA = 3'd4, IN0_DATA_INV = 3'd5
  } in0_sel_e;

  typedef enum logic [1:0] {
    IN1_ACC = 2'd0, IN1_REG = 2'd1, IN1_ONE = 2'd2, IN1_ONE_INV = 2'd3
  } in1_sel_e;

  typedef enum logic [1:0] {
    CIN_ZERO = 2'd0, CIN_ONE = 2'd1, CIN_CARRY = 2'd2, CIN_CARRY_INV = 2'd3
  } cin_sel_e;

  phase_e            phase_q;
  phase_e            phase_d;
  logic [DATA_W-1:0] opr;
  logic [DATA_W-1:0] opa;

  alu_op_e           op_sel;
  in0_sel_e          in0_sel;
  in1_sel_e          in1_sel;
  cin_sel_e          cin_sel;
  logic              wr_acc;
  logic              wr_carry;
  logic              wr_reg;
  logic              wr_phase;

  // Phase sequencer: free-running A1..X3 ring
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_A1;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_A1: phase_d = PH_A2;
      PH_A2: phase_d = PH_A3;
      PH_A3: phase_d = PH_M1;
      PH_M1: phase_d = PH_M2;
      PH_M2: phase_d = PH_X1;
      PH_X1: phase_d = PH_X2;
      PH_X2: phase_d = PH_X3;
      PH_X3: phase_d = PH_A1;
    endcase
  end

  // Instruction fetch: OPR in M1, OPA in M2
  always_ff @(posedge clock) begin
    if (reset) begin
      opr <= '0;
      opa <= '0;
    end else begin
      if (phase_q == PH_M1) opr <= data_in;
      if (phase_q == PH_M2) opa <= data_in;
    end
  end

  // Decode: selects follow the latched instruction; anything unrecognised
  // (including bytes of two-byte instructions) passes ACC and writes nothing.
  always_comb begin
    op_sel   = ALU_PASS;
    in0_sel  = IN0_ACC;
    in1_sel  = IN1_ACC;
    cin_sel  = CIN_ZERO;
    wr_acc   = 1'b0;
    wr_carry = 1'b0;
    wr_reg   = 1'b0;
    case (opr)
      4'h6: begin // INC Rn
        op_sel = ALU_ADD; in0_sel = IN0_REG; in1_sel = IN1_ONE;
        wr_reg = 1'b1;
      end
      4'h8: begin // ADD Rn
        op_sel = ALU_ADD; in0_sel = IN0_REG; cin_sel = CIN_CARRY;
        wr_acc = 1'b1; wr_carry = 1'b1;
      end
      4'h9: begin // SUB Rn: acc + ~Rn + ~carry
        op_sel = ALU_ADD; in0_sel = IN0_REG_INV; cin_sel = CIN_CARRY_INV;
        wr_acc = 1'b1; wr_carry = 1'b1;
      end
      4'hA: begin // LD Rn
        in0_sel = IN0_REG; cin_sel = CIN_CARRY;
        wr_acc = 1'b1;
      end
      4'hD: begin // LDM n
        in0_sel = IN0_DATA;
        wr_acc = 1'b1;
      end
      4'hF: begin
        case (opa)
          4'h0: begin // CLB: OPA is zero, so DATA pass clears both
            in0_sel = IN0_DATA;
            wr_acc = 1'b1; wr_carry = 1'b1;
          end
          4'h1: wr_carry = 1'b1; // CLC
          4'h2: begin // IAC
            op_sel = ALU_ADD; in1_sel = IN1_ONE;
            wr_acc = 1'b1; wr_carry = 1'b1;
          end
          4'h3: begin // CMC
            cin_sel = CIN_CARRY_INV;
            wr_carry = 1'b1;
          end
          4'h4: begin // CMA
            in0_sel = IN0_ACC_INV;
            wr_acc = 1'b1;
          end
          4'h5: begin // RAL
            op_sel = ALU_ROL; cin_sel = CIN_CARRY;
            wr_acc = 1'b1; wr_carry = 1'b1;
          end
          4'h6: begin // RAR
            op_sel = ALU_ROR; cin_sel = CIN_CARRY;
            wr_acc = 1'b1; wr_carry = 1'b1;
          end
          4'h8: begin // DAC: acc + 0xE + 1
            op_sel = ALU_ADD; in1_sel = IN1_ONE_INV; cin_sel = CIN_ONE;
            wr_acc = 1'b1; wr_carry = 1'b1;
          end
          4'hA: begin // STC
            cin_sel = CIN_ONE;
            wr_carry = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign wr_phase = (phase_q == PH_X1);

  // Writeback: commit on the edge ending X1; reset in that cycle wins
  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (wr_phase) begin
      if (wr_acc)   acc   <= result[DATA_W-1:0];
      if (wr_carry) carry <= result[DATA_W];
    end
  end

  assign alu_op      = op_sel;
  assign alu_in0_sel = in0_sel;
  assign alu_in1_sel = in1_sel;
  assign alu_cin_sel = cin_sel;
  assign alu_data    = opa;
  assign reg_idx     = opa;
  assign reg_wdata   = result[DATA_W-1:0];
  // Gated by reset so a reset landing in X1 cannot leak a register write.
  assign reg_we      = wr_phase & wr_reg & ~reset;
  assign phase       = phase_q;
  assign sync        = (phase_q == PH_X3) & ~reset;

endmodule

// File: tb/tb_alu_sequencer_project_id.sv
module tb_alu_sequencer_project_id;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic [4:0] result;
  logic [2:0] alu_op;
  logic [2:0] alu_in0_sel;
  logic [1:0] alu_in1_sel;
  logic [1:0] alu_cin_sel;
  logic [3:0] alu_data;
  logic [3:0] acc;
  logic       carry;
  logic [3:0] reg_idx;
  logic       reg_we;
  logic [3:0] reg_wdata;
  logic [2:0] phase;
  logic       sync;

  always #5 clock = ~clock;

  alu_sequencer_project_id dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .result      (result),
    .alu_op      (alu_op),
    .alu_in0_sel (alu_in0_sel),
    .alu_in1_sel (alu_in1_sel),
    .alu_cin_sel (alu_cin_sel),
    .alu_data    (alu_data),
    .acc         (acc),
    .carry       (carry),
    .reg_idx     (reg_idx),
    .reg_we      (reg_we),
    .reg_wdata   (reg_wdata),
    .phase       (phase),
    .sync        (sync)
  );

  // Environment: register file and ALU around the sequencer
  logic [3:0] env_regs [16];
  logic       poke_en  = 1'b0;
  logic [3:0] poke_idx = 4'h0;
  logic [3:0] poke_val = 4'h0;

  always @(posedge clock) begin
    if (poke_en)     env_regs[poke_idx] <= poke_val;
    else if (reg_we) env_regs[reg_idx]  <= reg_wdata;
  end

  logic [3:0] a_in0;
  logic [3:0] a_in1;
  logic       a_cin;
  always_comb begin
    a_in0 = acc;
    a_in1 = acc;
    a_cin = 1'b0;
    result = 5'h0;
    case (alu_in0_sel)
      3'd0: a_in0 = acc;
      3'd1: a_in0 = ~acc;
      3'd2: a_in0 = env_regs[reg_idx];
      3'd3: a_in0 = ~env_regs[reg_idx];
      3'd4: a_in0 = alu_data;
      3'd5: a_in0 = ~alu_data;
      default: a_in0 = acc;
    endcase
    case (alu_in1_sel)
      2'd0: a_in1 = acc;
      2'd1: a_in1 = env_regs[reg_idx];
      2'd2: a_in1 = 4'h1;
      default: a_in1 = 4'hE;
    endcase
    case (alu_cin_sel)
      2'd0: a_cin = 1'b0;
      2'd1: a_cin = 1'b1;
      2'd2: a_cin = carry;
      default: a_cin = ~carry;
    endcase
    case (alu_op)
      3'd0: result = {1'b0, a_in0} + {1'b0, a_in1} + {4'h0, a_cin};
      3'd1: result = {a_in0, a_cin};
      3'd2: result = {a_in0[0], a_cin, a_in0[3:1]};
      default: result = {a_cin, a_in0};
    endcase
  end

  // Checking infrastructure
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic [3:0] opr;
    logic [3:0] opa;
    logic [9:0] sel;
    logic       we;
    logic [3:0] old_acc;
    logic       old_c;
    logic [3:0] new_acc;
    logic       new_c;
    logic [3:0] new_reg;
  } exp_t;

  exp_t sb_q[$];

  // Reference machine state
  logic [3:0] m_acc = 4'h0;
  logic       m_c   = 1'b0;
  logic [3:0] m_regs [16];

  function automatic logic [9:0] sel4(input logic [2:0] op, input logic [2:0] i0,
                                      input logic [1:0] i1, input logic [1:0] ci);
    return {op, i0, i1, ci};
  endfunction

  // Expected selects straight from the instruction table
  function automatic logic [9:0] exp_sel(input logic [3:0] opr, input logic [3:0] opa);
    case (opr)
      4'h6: return sel4(3'd0, 3'd2, 2'd2, 2'd0);
      4'h8: return sel4(3'd0, 3'd2, 2'd0, 2'd2);
      4'h9: return sel4(3'd0, 3'd3, 2'd0, 2'd3);
      4'hA: return sel4(3'd3, 3'd2, 2'd0, 2'd2);
      4'hD: return sel4(3'd3, 3'd4, 2'd0, 2'd0);
      4'hF: begin
        case (opa)
          4'h0: return sel4(3'd3, 3'd4, 2'd0, 2'd0);
          4'h1: return sel4(3'd3, 3'd0, 2'd0, 2'd0);
          4'h2: return sel4(3'd0, 3'd0, 2'd2, 2'd0);
          4'h3: return sel4(3'd3, 3'd0, 2'd0, 2'd3);
          4'h4: return sel4(3'd3, 3'd1, 2'd0, 2'd0);
          4'h5: return sel4(3'd1, 3'd0, 2'd0, 2'd2);
          4'h6: return sel4(3'd2, 3'd0, 2'd0, 2'd2);
          4'h8: return sel4(3'd0, 3'd0, 2'd3, 2'd1);
          4'hA: return sel4(3'd3, 3'd0, 2'd0, 2'd1);
          default: return sel4(3'd3, 3'd0, 2'd0, 2'd0);
        endcase
      end
      default: return sel4(3'd3, 3'd0, 2'd0, 2'd0);
    endcase
  endfunction

  // Instruction semantics in plain arithmetic
  task automatic ref_step(input logic [3:0] opr, input logic [3:0] opa);
    int r;
    int a;
    int c;
    int t;
    r = int'(m_regs[opa]);
    a = int'(m_acc);
    c = int'(m_c);
    case (opr)
      4'h6: m_regs[opa] = 4'((r + 1) % 16);
      4'h8: begin t = a + r + c;             m_acc = 4'(t % 16); m_c = (t >= 16); end
      4'h9: begin t = a + (15 - r) + (1 - c); m_acc = 4'(t % 16); m_c = (t >= 16); end
      4'hA: m_acc = 4'(r);
      4'hD: m_acc = opa;
      4'hF: begin
        case (opa)
          4'h0: begin m_acc = 4'h0; m_c = 1'b0; end
          4'h1: m_c = 1'b0;
          4'h2: begin t = a + 1;  m_acc = 4'(t % 16); m_c = (t >= 16); end
          4'h3: m_c = (c == 0);
          4'h4: m_acc = 4'(15 - a);
          4'h5: begin t = a * 2 + c; m_acc = 4'(t % 16); m_c = (t >= 16); end
          4'h6: begin m_c = (a % 2 == 1); m_acc = 4'(a / 2 + 8 * c); end
          4'h8: begin t = a + 15; m_acc = 4'(t % 16); m_c = (t >= 16); end
          4'hA: m_c = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    @(negedge clock);
    while (int'(phase) != p && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (int'(phase) != p) check("phase_wait_timeout", int'(phase), p);
  endtask

  task automatic issue(input logic [3:0] opr, input logic [3:0] opa, input bit track);
    exp_t e;
    wait_phase(3);
    data_in = opr;
    @(negedge clock);
    data_in = opa;
    if (track) begin
      e.opr     = opr;
      e.opa     = opa;
      e.sel     = exp_sel(opr, opa);
      e.we      = (opr == 4'h6);
      e.old_acc = m_acc;
      e.old_c   = m_c;
      ref_step(opr, opa);
      e.new_acc = m_acc;
      e.new_c   = m_c;
      e.new_reg = m_regs[opa];
      sb_q.push_back(e);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [3:0] val);
    @(negedge clock);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    m_regs[idx] = val;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Monitor: pops an expectation at X1 and checks committed state in X2
  exp_t cur;
  bit   have_cur = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      have_cur = 1'b0;
    end else if (phase == 3'd5 && sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      have_cur = 1'b1;
      check("selects", int'({alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel}), int'(cur.sel));
      check("reg_we_x1", int'(reg_we), int'(cur.we));
      check("alu_data", int'(alu_data), int'(cur.opa));
      check("acc_before_write", int'(acc), int'(cur.old_acc));
      check("carry_before_write", int'(carry), int'(cur.old_c));
    end else if (phase == 3'd6 && have_cur) begin
      have_cur = 1'b0;
      check("acc", int'(acc), int'(cur.new_acc));
      check("carry", int'(carry), int'(cur.new_c));
      check("reg_value", int'(env_regs[cur.opa]), int'(cur.new_reg));
      check("reg_we_x2", int'(reg_we), 0);
    end
  end

  logic [3:0] valid_opr [6] = '{4'h6, 4'h8, 4'h9, 4'hA, 4'hD, 4'hF};

  initial begin
    logic [3:0] v;
    logic [3:0] o;
    logic [3:0] a;

    // Reset: preload register file while held in reset
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = 4'($urandom_range(0, 15));
      @(negedge clock);
      poke_en  = 1'b1;
      poke_idx = 4'(i);
      poke_val = v;
      m_regs[i] = v;
    end
    @(negedge clock);
    poke_en = 1'b0;
    check("rst_phase", int'(phase), 0);
    check("rst_acc", int'(acc), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_sync", int'(sync), 0);
    check("rst_reg_we", int'(reg_we), 0);
    check("rst_opa", int'(alu_data), 0);
    check("rst_nop_op", int'(alu_op), 3);
    reset = 1'b0;

    // Phase ring after release
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      check("phase_count", int'(phase), i);
      check("sync", int'(sync), (i == 7) ? 1 : 0);
    end
    check("post_rel_acc", int'(acc), 0);
    check("post_rel_carry", int'(carry), 0);

    // Directed instruction scenarios
    issue(4'hD, 4'h5, 1'b1);          // LDM 5
    issue(4'hD, 4'h9, 1'b1);          // LDM 9
    issue(4'hF, 4'hA, 1'b1);          // STC
    poke(4'h3, 4'h7);
    issue(4'h8, 4'h3, 1'b1);          // ADD R3 -> acc 1, carry 1
    issue(4'hD, 4'hA, 1'b1);          // LDM A
    issue(4'hF, 4'h1, 1'b1);          // CLC
    issue(4'hF, 4'h5, 1'b1);          // RAL -> 4, 1
    issue(4'hF, 4'h6, 1'b1);          // RAR -> A, 0
    issue(4'hD, 4'h0, 1'b1);          // LDM 0
    issue(4'hF, 4'h8, 1'b1);          // DAC -> F, 0
    issue(4'hD, 4'h3, 1'b1);          // LDM 3
    issue(4'hF, 4'h8, 1'b1);          // DAC -> 2, 1
    issue(4'h2, 4'h4, 1'b1);          // two-byte opcode byte: NOP
    issue(4'hF, 4'hF, 1'b1);          // unused F-group code: NOP

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) != 0) o = valid_opr[$urandom_range(0, 5)];
      else                           o = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      issue(o, a, 1'b1);
    end

    // Reset landing in X1 of INC R2 with R2 = F
    wait_phase(7);
    poke(4'h2, 4'hF);
    issue(4'h6, 4'h2, 1'b0);
    wait_phase(5);
    reset = 1'b1;
    #1;
    check("x1_rst_reg_we", int'(reg_we), 0);
    @(negedge clock);
    check("x1_rst_phase", int'(phase), 0);
    check("x1_rst_acc", int'(acc), 0);
    check("x1_rst_carry", int'(carry), 0);
    check("x1_rst_r2_kept", int'(env_regs[2]), 15);
    check("x1_rst_opa", int'(alu_data), 0);
    reset = 1'b0;
    m_acc = 4'h0;
    m_c   = 1'b0;
    #1;
    check("x1_rel_phase", int'(phase), 0);

    // Machine resumes from A1 after release
    issue(4'hF, 4'h2, 1'b1);          // IAC -> 1
    issue(4'h6, 4'h2, 1'b1);          // INC R2 -> 0
    wait_phase(7);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
